// File: rtl/branch_pkg.sv
// Shared encodings for the branch-resolve slice: funct3 codes and FSM states.
package branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_REDIRECT = 2'd1;
   localparam logic [1:0] S_FLUSH    = 2'd2;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decode: {funct3, eq, lt} -> {taken, illegal}.
module branch_cond
   import branch_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       eq,
   input  logic       lt,
   output logic       taken,
   output logic       illegal
);

   // funct3[1] only selects signedness in the comparator, so BLT/BLTU and
   // BGE/BGEU share a condition here.
   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3_BEQ:           taken = eq;
         F3_BNE:           taken = !eq;
         F3_BLT, F3_BLTU:  taken = lt;
         F3_BGE, F3_BGEU:  taken = !lt;
         default:          illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolve: consumes comparator results, redirects fetch on taken
// branches, then holds a pipeline flush for FLUSH_CYCLES cycles.
module branch_resolve
   import branch_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_funct3,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [WIDTH-1:0] in_imm,
   output logic             br_un,
   input  logic             br_eq,
   input  logic             br_lt,
   output logic             redirect_valid,
   input  logic             redirect_ready,
   output logic [WIDTH-1:0] redirect_pc,
   output logic             flush,
   output logic             illegal,
   output logic             misalign,
   output logic [CNT_W-1:0] taken_count
);

   localparam int FC_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

   logic [1:0]       state;
   logic [FC_W-1:0]  flush_cnt;
   logic             accept;
   logic             c_taken;
   logic             c_illegal;
   logic [WIDTH-1:0] target;

   branch_cond u_cond (
      .funct3  (in_funct3),
      .eq      (br_eq),
      .lt      (br_lt),
      .taken   (c_taken),
      .illegal (c_illegal)
   );

   // Comparator mode and handshake are pure functions of the inputs/state.
   always_comb begin
      br_un    = in_funct3[1];
      in_ready = (state == S_IDLE) & rst_n;
      accept   = in_valid & in_ready;
      target   = in_pc + in_imm;
   end

   // Main FSM; error pulses default low so they last exactly one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         flush_cnt      <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush          <= 1'b0;
         illegal        <= 1'b0;
         misalign       <= 1'b0;
         taken_count    <= '0;
      end else begin
         illegal  <= 1'b0;
         misalign <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (c_illegal) begin
                     illegal <= 1'b1;
                  end else if (c_taken) begin
                     if (target[1:0] != 2'b00) begin
                        misalign <= 1'b1;
                     end else begin
                        redirect_pc    <= target;
                        redirect_valid <= 1'b1;
                        if (taken_count != '1)
                           taken_count <= taken_count + 1'b1;
                        state <= S_REDIRECT;
                     end
                  end
               end
            end
            S_REDIRECT: begin
               if (redirect_ready) begin
                  redirect_valid <= 1'b0;
                  if (FLUSH_CYCLES > 0) begin
                     flush     <= 1'b1;
                     flush_cnt <= FC_W'(FLUSH_CYCLES);
                     state     <= S_FLUSH;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_FLUSH: begin
               if (flush_cnt == FC_W'(1)) begin
                  flush <= 1'b0;
                  state <= S_IDLE;
               end
               flush_cnt <= flush_cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: default build plus a CNT_W=2 build
// driven with the same stimulus to exercise counter saturation.
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [2:0]  in_funct3;
   logic [31:0] in_pc, in_imm;
   logic        br_eq, br_lt;
   logic        redirect_ready;

   logic        in_ready, br_un, redirect_valid, flush, illegal, misalign;
   logic [31:0] redirect_pc;
   logic [15:0] taken_count;

   logic        in_ready2, br_un2, redirect_valid2, flush2, illegal2, misalign2;
   logic [31:0] redirect_pc2;
   logic [1:0]  taken_count2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_resolve dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm), .br_un(br_un),
      .br_eq(br_eq), .br_lt(br_lt), .redirect_valid(redirect_valid),
      .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .flush(flush),
      .illegal(illegal), .misalign(misalign), .taken_count(taken_count)
   );

   branch_resolve #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm), .br_un(br_un2),
      .br_eq(br_eq), .br_lt(br_lt), .redirect_valid(redirect_valid2),
      .redirect_ready(redirect_ready), .redirect_pc(redirect_pc2), .flush(flush2),
      .illegal(illegal2), .misalign(misalign2), .taken_count(taken_count2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                     input logic eq, input logic lt);
      in_valid  = 1'b1;
      in_funct3 = f3;
      in_pc     = pc;
      in_imm    = imm;
      br_eq     = eq;
      br_lt     = lt;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_funct3 = 3'b000; in_pc = '0; in_imm = '0;
      br_eq = 1'b0; br_lt = 1'b0; redirect_ready = 1'b0;
      step(); step();
      chk("rst_rv", redirect_valid, 0);
      chk("rst_flush", flush, 0);
      chk("rst_ill", illegal, 0);
      chk("rst_mis", misalign, 0);
      chk("rst_pc", redirect_pc, 0);
      chk("rst_cnt", taken_count, 0);
      chk("rst_rdy_low", in_ready, 0);
      rst_n = 1'b1; #1;
      chk("rst_rdy", in_ready, 1);

      // BEQ taken, flush for two cycles
      br(3'b000, 32'h100, 32'h20, 1'b1, 1'b0);
      step(); in_valid = 1'b0;
      chk("beq_rv", redirect_valid, 1);
      chk("beq_pc", redirect_pc, 32'h120);
      chk("beq_cnt", taken_count, 1);
      chk("beq_rdy", in_ready, 0);
      redirect_ready = 1'b1;
      step(); redirect_ready = 1'b0;
      chk("beq_rv0", redirect_valid, 0);
      chk("beq_fl1", flush, 1);
      step();
      chk("beq_fl2", flush, 1);
      chk("beq_fl_rdy", in_ready, 0);
      step();
      chk("beq_fl3", flush, 0);
      chk("beq_rdy2", in_ready, 1);

      // Back-to-back not-taken: BLTU lt=0 then BGE lt=1
      br(3'b110, 32'h300, 32'h40, 1'b0, 1'b0); #1;
      chk("bltu_un", br_un, 1);
      chk("bltu_rdy", in_ready, 1);
      step();
      br(3'b101, 32'h300, 32'h40, 1'b0, 1'b1); #1;
      chk("bge_un", br_un, 0);
      chk("bge_rdy", in_ready, 1);
      step(); in_valid = 1'b0;
      chk("nt_rv", redirect_valid, 0);
      chk("nt_cnt", taken_count, 1);
      chk("nt_rdy", in_ready, 1);

      // BNE with wrapping target, fetch stalls 5 cycles
      br(3'b001, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0);
      step(); in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bne_rv_hold", redirect_valid, 1);
         chk("bne_pc_hold", redirect_pc, 32'h10);
         chk("bne_rdy_hold", in_ready, 0);
         step();
      end
      chk("bne_rv6", redirect_valid, 1);
      redirect_ready = 1'b1;
      step(); redirect_ready = 1'b0;
      chk("bne_fl", flush, 1);
      chk("bne_rv0", redirect_valid, 0);
      chk("bne_cnt", taken_count, 2);
      step(); step();
      chk("bne_fl_end", flush, 0);

      // Illegal funct3, then misaligned target
      br(3'b010, 32'h100, 32'h20, 1'b1, 1'b1);
      step(); in_valid = 1'b0;
      chk("ill_p", illegal, 1);
      chk("ill_rv", redirect_valid, 0);
      step();
      chk("ill_p0", illegal, 0);
      br(3'b000, 32'h100, 32'h6, 1'b1, 1'b0);
      step(); in_valid = 1'b0;
      chk("mis_p", misalign, 1);
      chk("mis_rv", redirect_valid, 0);
      chk("mis_cnt", taken_count, 2);
      chk("mis_rdy", in_ready, 1);
      step();
      chk("mis_p0", misalign, 0);

      // Reset during FLUSH
      br(3'b000, 32'h200, 32'h10, 1'b1, 1'b0);
      step(); in_valid = 1'b0;
      redirect_ready = 1'b1;
      step(); redirect_ready = 1'b0;
      chk("rf_fl", flush, 1);
      rst_n = 1'b0;
      step();
      chk("rf_flush", flush, 0);
      chk("rf_cnt", taken_count, 0);
      chk("rf_pc", redirect_pc, 0);
      rst_n = 1'b1; #1;
      chk("rf_rdy", in_ready, 1);

      // Reset during REDIRECT
      br(3'b100, 32'h400, 32'h8, 1'b0, 1'b1);
      step(); in_valid = 1'b0;
      chk("rr_rv", redirect_valid, 1);
      chk("rr_pc", redirect_pc, 32'h408);
      rst_n = 1'b0;
      step();
      chk("rr_rv0", redirect_valid, 0);
      chk("rr_pc0", redirect_pc, 0);
      chk("rr_cnt", taken_count, 0);
      rst_n = 1'b1; #1;
      chk("rr_rdy", in_ready, 1);
      step();
      chk("rr_idle_rv", redirect_valid, 0);

      // Five taken branches: 16-bit counter reaches 5, 2-bit build saturates at 3
      for (int i = 0; i < 5; i++) begin
         br(3'b111, 32'h100, 32'h40, 1'b0, 1'b0);
         step(); in_valid = 1'b0;
         chk("sat_cnt", taken_count, i + 1);
         chk("sat_cnt2", taken_count2, (i < 3) ? i + 1 : 3);
         redirect_ready = 1'b1;
         step(); redirect_ready = 1'b0;
         step(); step();
      end
      chk("sat_final", taken_count, 5);
      chk("sat_final2", taken_count2, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumer side of the branch comparator in the RISC-V core.
- Accepts one decoded conditional branch per handshake and drives br_un into the comparator. It takes br_eq/br_lt back in the same cycle and decides taken/not-taken per funct3.
- On a taken branch it issues a PC redirect to fetch over a valid/ready handshake, then asserts a pipeline flush for a fixed number of cycles.
- Also flags illegal funct3 and misaligned targets, and counts taken branches.

Parameters:
- WIDTH, 32, data/address width; matches the comparator operand width.
- FLUSH_CYCLES, 2, cycles flush stays high after redirect acceptance; 0 allowed.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  branch op presented
- in_ready  output  1  block can accept an op
- in_funct3  input  3  branch funct3
- in_pc  input  WIDTH  PC of branch
- in_imm  input  WIDTH  sign-extended B-immediate
- br_un  output  1  to comparator cmpop; 1 = unsigned compare
- br_eq  input  1  from comparator; rs1 == rs2
- br_lt  input  1  from comparator; rs1 < rs2 (signed/unsigned per br_un)
- redirect_valid  output  1  redirect target valid
- redirect_ready  input  1  fetch accepts redirect
- redirect_pc  output  WIDTH  branch target
- flush  output  1  kill younger instructions
- illegal  output  1  one-cycle pulse: bad funct3
- misalign  output  1  one-cycle pulse: taken target not 4-byte aligned
- taken_count  output  CNT_W  saturating count of taken branches

Behaviour:
- Reset (rst_n=0 at a clk edge), regardless of state:
  - state=IDLE.
  - redirect_valid, flush, illegal, misalign = 0.
  - redirect_pc = 0, taken_count = 0.
  - Reset mid-REDIRECT or mid-FLUSH abandons the operation; no redirect completes.
- br_un is combinational: br_un = in_funct3[1]. It is valid whenever in_valid=1, whatever the state.
- br_eq/br_lt are sampled in the accept cycle. accept = in_valid & in_ready.
- Condition decode:
  - 000 BEQ: taken = eq.
  - 001 BNE: taken = !eq.
  - 100 BLT and 110 BLTU: taken = lt.
  - 101 BGE and 111 BGEU: taken = !lt.
  - 010/011: illegal; taken = 0.
- Target = in_pc + in_imm, modulo 2^WIDTH (wrap, no carry out).
- States: IDLE, REDIRECT, FLUSH. in_ready = (state==IDLE) & rst_n.
- IDLE, on accept, outcome registered at the edge:
  - Illegal: illegal=1 for the next cycle; stay IDLE.
  - Not taken: stay IDLE; no outputs change.
  - Taken, target[1:0]!=0: misalign=1 for the next cycle; no redirect; stay IDLE; counter unchanged.
  - Taken, aligned: redirect_pc <= target; redirect_valid <= 1; taken_count += 1 (saturating at all-ones); go to REDIRECT.
- REDIRECT:
  - redirect_valid and redirect_pc are held stable until redirect_ready=1 at an edge. redirect_valid may sit high indefinitely.
  - On handshake: redirect_valid <= 0.
    - FLUSH_CYCLES>0: flush <= 1, load counter with FLUSH_CYCLES, go to FLUSH.
    - FLUSH_CYCLES=0: go to IDLE.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles; counter decrements each cycle.
  - At counter==1: flush <= 0, go to IDLE.
  - Next accept is possible the cycle after flush falls.
- Result latency: one cycle from accept to redirect_valid, illegal, or misalign.
- Back-to-back not-taken branches are accepted every cycle.

Decomposition:
- Shared package (branch_pkg):
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - State encoding S_IDLE, S_REDIRECT, S_FLUSH.
- Sub-module: branch_cond, combinational decode of {funct3, br_eq, br_lt} into {taken, illegal}. Reused by the verification model.
- Comparator stays external; this block does not instantiate it.

Test Plan:
- BEQ, eq=1, pc=0x100, imm=0x20 -> redirect_valid=1 next cycle, redirect_pc=0x120, taken_count=1. redirect_ready=1 -> flush high exactly 2 cycles, then in_ready=1.
- BLTU, lt=0, and BGE, lt=1, accepted in consecutive cycles -> br_un=1 then 0; no redirect; in_ready stays 1; taken_count unchanged.
- BNE, eq=0, pc=0xFFFFFFF0, imm=0x20 -> redirect_pc=0x00000010 (wrap). redirect_ready held 0 for 5 cycles -> redirect_valid and redirect_pc stable, in_ready=0. Ready on cycle 6 -> flush starts next cycle.
- funct3=010 -> illegal pulse 1 cycle, no redirect. BEQ, eq=1, pc=0x100, imm=0x6 -> misalign pulse, no redirect, counter unchanged.
- rst_n=0 during FLUSH, and separately during REDIRECT -> next cycle all outputs at reset values, state IDLE, taken_count=0.
- CNT_W=2 build: 5 aligned taken branches with handshakes -> taken_count saturates at 3.
